// File: rtl/uart_mike_tx_pkg.sv
// UART_MIKE_pkg: shared types and default constants for the UART TX path.
//   uart_tx_state_t        - serializer FSM state encoding
//   UART_DEF_CLKS_PER_BIT  - default clocks per serial bit
//   UART_DEF_DATA_W        - default data bits per frame
package UART_MIKE_pkg;

    localparam int unsigned UART_DEF_CLKS_PER_BIT = 434;
    localparam int unsigned UART_DEF_DATA_W       = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_tx_state_t;

endpackage

// File: rtl/uart_mike_tx_if.sv
// uart_mike_tx_if: control FSM <-> UART serializer signal bundle.
//   tx_inprg, tx_data_cnt_delete, tx_data, parity_en, parity_odd : controller -> serializer
//   tx_serial, tx_busy, tx_done                                  : serializer -> controller/pad
// master = control FSM side, slave = serializer side.
interface uart_mike_tx_if #(
    parameter int unsigned DATA_W = UART_MIKE_pkg::UART_DEF_DATA_W
);
    logic              tx_inprg;
    logic              tx_data_cnt_delete;
    logic [DATA_W-1:0] tx_data;
    logic              parity_en;
    logic              parity_odd;
    logic              tx_serial;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output tx_inprg, tx_data_cnt_delete, tx_data, parity_en, parity_odd,
        input  tx_serial, tx_busy, tx_done
    );

    modport slave (
        input  tx_inprg, tx_data_cnt_delete, tx_data, parity_en, parity_odd,
        output tx_serial, tx_busy, tx_done
    );
endinterface

// File: rtl/UART_MIKE_header.svh
// Shared macros for the UART_MIKE codebase.
// UART_MIKE_DFF_RN: register with synchronous active-low reset.
// The enclosing scope must provide `clk` and `n_rst`.
`ifndef UART_MIKE_HEADER_SVH
`define UART_MIKE_HEADER_SVH

`define UART_MIKE_DFF_RN(q, d, rst_val) \
    always_ff @(posedge clk) begin \
        if (!n_rst) q <= rst_val; \
        else        q <= d; \
    end

`endif

// File: rtl/uart_mike_baud_tick.sv
// uart_mike_baud_tick: baud counter for the UART serializer.
//   clk, n_rst : clock, synchronous active-low reset
//   clr        : force the count back to 0 on the next edge
//   bit_end    : high in the last cycle of a bit (count == CLKS_PER_BIT-1)
`include "UART_MIKE_header.svh"

module uart_mike_baud_tick
    import UART_MIKE_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    output logic bit_end
);
    localparam int unsigned      CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || bit_end) cnt_d = '0;
    end

    `UART_MIKE_DFF_RN(cnt_q, cnt_d, '0)

endmodule

// File: rtl/uart_mike_tx.sv
// uart_mike_tx: UART serializer (start bit, DATA_W bits LSB first,
// optional parity, one stop bit).
//   clk, n_rst : clock, synchronous active-low reset
//   bus        : uart_mike_tx_if.slave
//                in : tx_inprg (request/hold), tx_data_cnt_delete (abort),
//                     tx_data, parity_en, parity_odd (latched on accept)
//                out: tx_serial (registered line), tx_busy (START..STOP),
//                     tx_done (DONE state)
`include "UART_MIKE_header.svh"

module uart_mike_tx
    import UART_MIKE_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_W       = UART_DEF_DATA_W
) (
    input  logic           clk,
    input  logic           n_rst,
    uart_mike_tx_if.slave  bus
);
    localparam int unsigned      BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

    uart_tx_state_t    state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic bit_end;
    logic baud_clr;

    uart_mike_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (baud_clr),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        case (state_q)
            IDLE: begin
                if (bus.tx_inprg) begin
                    shift_d   = bus.tx_data;
                    par_en_d  = bus.parity_en;
                    par_bit_d = (^bus.tx_data) ^ bus.parity_odd;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_MAX) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = DONE;
            end
            DONE: begin
                // Wait for the request to drop so a slow controller cannot
                // trigger a second frame.
                if (!bus.tx_inprg) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.tx_data_cnt_delete) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end
    end

    // Baud count restarts on every state change and is parked outside
    // the line-driving states.
    assign baud_clr = bus.tx_data_cnt_delete || (state_d != state_q) ||
                      (state_q == IDLE) || (state_q == DONE);

    // Outputs are decoded from the next state so the line flop changes
    // in the same cycle the state does.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_bit_d;
            default: serial_d = 1'b1;
        endcase
        busy_d = (state_d == START) || (state_d == DATA) ||
                 (state_d == PARITY) || (state_d == STOP);
        done_d = (state_d == DONE);
    end

    `UART_MIKE_DFF_RN(state_q,   state_d,   IDLE)
    `UART_MIKE_DFF_RN(shift_q,   shift_d,   '0)
    `UART_MIKE_DFF_RN(bit_cnt_q, bit_cnt_d, '0)
    `UART_MIKE_DFF_RN(par_en_q,  par_en_d,  1'b0)
    `UART_MIKE_DFF_RN(par_bit_q, par_bit_d, 1'b0)
    `UART_MIKE_DFF_RN(serial_q,  serial_d,  1'b1)
    `UART_MIKE_DFF_RN(busy_q,    busy_d,    1'b0)
    `UART_MIKE_DFF_RN(done_q,    done_d,    1'b0)

    assign bus.tx_serial = serial_q;
    assign bus.tx_busy   = busy_q;
    assign bus.tx_done   = done_q;

endmodule

// File: doc/uart_mike_tx.md
# uart_mike_tx

UART serializer driven by the UART control FSM. It turns a parallel byte into an asynchronous serial frame: start bit, data LSB first, optional parity, one stop bit. It starts a frame on `tx_inprg`, reports completion on `tx_done`, and clears itself on `tx_data_cnt_delete`. It sits between the control FSM and the TX pad.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit; must be at least 2.
- `DATA_W`, default 8: data bits per frame.
- `clk`  in  1  single clock; all logic on its rising edge.
- `n_rst`  in  1  reset, synchronous and active-low.
- `tx_inprg`  in  1  transmit request/hold from the control FSM.
- `tx_data_cnt_delete`  in  1  abort/clear strobe from the control FSM; overrides everything except reset.
- `tx_data`  in  DATA_W  byte to send; sampled only when a frame is accepted.
- `parity_en`  in  1  1 = append a parity bit; sampled when a frame is accepted.
- `parity_odd`  in  1  1 = odd parity, 0 = even; sampled when a frame is accepted.
- `tx_serial`  out  1  serial line; idles high; driven from a flop.
- `tx_busy`  out  1  high while a frame is on the line (states START through STOP).
- `tx_done`  out  1  high while in DONE.

## Operation
- Reset values: state IDLE, `tx_serial`=1, `tx_busy`=0, `tx_done`=0, all counters 0, shift register 0.
- States:
  - IDLE: line is 1. `tx_inprg`=1 accepts a frame: latch `tx_data`, `parity_en` and `parity_odd`, compute parity, go to START.
  - START: line is 0.
  - DATA: line carries `shift[0]`; the register shifts right at the end of each bit. Leave after DATA_W bits.
  - PARITY: entered only if the latched `parity_en`=1.
    - Even parity bit = XOR of all data bits.
    - Odd parity bit = inverse of that.
  - STOP: line is 1 for one bit time.
  - DONE: line is 1 and `tx_done`=1. Return to IDLE when `tx_inprg`=0.
- Each line-driving state lasts exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state change.
  - Counter width is $clog2(CLKS_PER_BIT).
  - The bit counter runs 0..DATA_W-1.
- `tx_data_cnt_delete`=1 in any state:
  - Next cycle: state IDLE, all counters 0, `tx_serial`=1, `tx_busy`=0, `tx_done`=0.
  - No `tx_done` is produced for an aborted frame.
- `tx_inprg` falling before DONE is ignored; the frame completes. Only the delete strobe aborts.
- `tx_data` changing mid-frame has no effect.
- If `tx_inprg` stays high through DONE, the block remains in DONE. It never starts a second frame without first seeing `tx_inprg` low. This prevents a double send when the controller is slow to drop its request.
- Reset asserted mid-frame: on the next edge the block is in reset values; the line goes high immediately, with no partial stop bit.

## Timing
- Acceptance: edge *k* samples `tx_inprg`=1 in IDLE. From cycle *k*+1, `tx_serial`=0 and `tx_busy`=1.
- Frame length: (2 + DATA_W + parity_en) × CLKS_PER_BIT cycles from cycle *k*+1.
- `tx_done` rises in the first cycle after the last stop-bit cycle. It stays high until the cycle after `tx_inprg` is sampled low, with a minimum of 1 cycle.
- Delete and reset take effect one cycle after being sampled.
- Delete wins over a simultaneous `tx_inprg`=1 in IDLE: the frame is not accepted.
- Back-to-back frames: minimum one IDLE cycle between DONE and the next START.

## Structure
- Shared package `UART_MIKE_pkg`:
  - typedef `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP, DONE).
  - constants `UART_DEF_CLKS_PER_BIT`=434 and `UART_DEF_DATA_W`=8.
- Flops use the codebase's standard synchronous active-low reset register macro from `UART_MIKE_header.svh`.
- One natural sub-module: `uart_mike_baud_tick`, which holds the baud counter. It has a clear input and outputs a one-cycle `bit_end` pulse when the count reaches CLKS_PER_BIT-1.

## Test plan
- **Basic frame:** CLKS_PER_BIT=4, no parity, `tx_data`=0xA5, one-cycle `tx_inprg` at edge 0.
  - Line in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` high for cycles 1–40; `tx_done` in cycle 41; line high afterwards.
- **Parity:** `parity_en`=1.
  - Even, 0x07 → parity bit 1.
  - Even, 0x03 → 0.
  - Odd, 0x00 → 1.
  - In each case the frame is 44 cycles at CLKS_PER_BIT=4.
- **Abort:** `tx_data_cnt_delete` during data bit 3 → next cycle `tx_serial`=1, `tx_busy`=0, state IDLE. `tx_done` never asserts. A new request then sends a clean full frame.
- **Held request:** `tx_inprg` held high for 100 cycles after a frame → exactly one frame sent and `tx_done` held. Dropping `tx_inprg` returns the block to IDLE; raising it again starts frame two.
- **Reset mid-frame:** `n_rst`=0 during the stop bit → all outputs at reset values one edge later. No `tx_done` after `n_rst` rises.
- **Priority and latching:** delete and `tx_inprg` together in IDLE → no frame. Change `tx_data` mid-frame → the serialized bits still match the latched byte.
